// File: rtl/bfp_pkg.sv
// Shared constants and FSM state type for the block-floating-point dot-product sequencer.
package bfp_pkg;

    localparam int SF_W       = 11;
    localparam int EXP_W      = 5;
    localparam int LANES      = 8;
    localparam int MAX_CHUNKS = 16;
    localparam int TREE_W     = 2*SF_W + 2;
    localparam int ACC_W      = TREE_W + $clog2(MAX_CHUNKS);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        OUT
    } state_t;

endpackage

// File: rtl/bfp_align_acc.sv
// Exponent-aligning accumulate step: shifts the smaller-exponent operand right
// (arithmetic, truncating) and adds it to the other one.
module bfp_align_acc #(
    parameter int ACC_W  = bfp_pkg::ACC_W,
    parameter int TREE_W = bfp_pkg::TREE_W,
    parameter int XW     = bfp_pkg::EXP_W + 1
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic        [XW-1:0]     acc_exp,
    input  logic signed [TREE_W-1:0] tree_result,
    input  logic        [XW-1:0]     tree_result_exp,
    input  logic                     first,
    output logic signed [ACC_W-1:0]  acc_next,
    output logic        [XW-1:0]     acc_exp_next
);

    // Shifts at or beyond the word width collapse to pure sign fill.
    function automatic logic signed [ACC_W-1:0] asr(input logic signed [ACC_W-1:0] x,
                                                    input logic [XW-1:0] d);
        logic signed [ACC_W-1:0] r;
        if (32'(d) >= ACC_W) r = {ACC_W{x[ACC_W-1]}};
        else                 r = x >>> d;
        return r;
    endfunction

    logic signed [ACC_W-1:0] tree_ext;
    assign tree_ext = ACC_W'(tree_result);

    always_comb begin
        acc_next     = tree_ext;
        acc_exp_next = tree_result_exp;
        if (!first) begin
            if (tree_result_exp >= acc_exp) begin
                acc_next = asr(acc, tree_result_exp - acc_exp) + tree_ext;
            end else begin
                acc_next     = acc + asr(tree_ext, acc_exp - tree_result_exp);
                acc_exp_next = acc_exp;
            end
        end
    end

endmodule

// File: rtl/bfp_dot_sequencer.sv
// Feeds 8-lane chunks to an external combinational adder tree and accumulates the
// tree results of each dot product into one (fraction, exponent) output.
module bfp_dot_sequencer #(
    parameter int SF_W       = bfp_pkg::SF_W,
    parameter int EXP_W      = bfp_pkg::EXP_W,
    parameter int MAX_CHUNKS = bfp_pkg::MAX_CHUNKS,
    parameter int TREE_W     = 2*SF_W + 2,
    parameter int ACC_W      = TREE_W + $clog2(MAX_CHUNKS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_last,
    input  logic [EXP_W-1:0]                  in_exp1,
    input  logic [EXP_W-1:0]                  in_exp2,
    input  logic [bfp_pkg::LANES*SF_W-1:0]    in_lanes,
    output logic [bfp_pkg::LANES*SF_W-1:0]    tree_lanes,
    output logic [EXP_W-1:0]                  tree_exp1,
    output logic [EXP_W-1:0]                  tree_exp2,
    input  logic signed [TREE_W-1:0]          tree_result,
    input  logic [EXP_W:0]                    tree_result_exp,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [ACC_W-1:0]           out_frac,
    output logic [EXP_W:0]                    out_exp,
    output logic                              out_trunc,
    output logic                              busy
);

    import bfp_pkg::*;

    localparam int CNT_W = $clog2(MAX_CHUNKS);

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        count_reg;
    logic                    s1_vld_reg;
    logic                    first_reg;
    logic                    trunc_reg;
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic [EXP_W:0]          acc_exp_reg, acc_exp_next;
    logic                    accept;
    logic                    count_hit;

    assign accept    = in_valid & in_ready;
    assign count_hit = (count_reg == CNT_W'(MAX_CHUNKS - 1));
    assign busy      = (state_reg != IDLE) | s1_vld_reg;

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        unique case (state_reg)
            IDLE, ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) state_next = (in_last || count_hit) ? DRAIN : ACCUM;
            end
            DRAIN:   state_next = OUT;
            OUT:     if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [SF_W-1:0] lane_reg;
        always_ff @(posedge clk) begin
            if (!rst_n)      lane_reg <= '0;
            else if (accept) lane_reg <= in_lanes[gi*SF_W +: SF_W];
        end
        assign tree_lanes[gi*SF_W +: SF_W] = lane_reg;
    end

    bfp_align_acc #(
        .ACC_W (ACC_W),
        .TREE_W(TREE_W),
        .XW    (EXP_W + 1)
    ) u_align (
        .acc            (acc_reg),
        .acc_exp        (acc_exp_reg),
        .tree_result    (tree_result),
        .tree_result_exp(tree_result_exp),
        .first          (first_reg),
        .acc_next       (acc_next),
        .acc_exp_next   (acc_exp_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            s1_vld_reg  <= 1'b0;
            first_reg   <= 1'b0;
            trunc_reg   <= 1'b0;
            acc_reg     <= '0;
            acc_exp_reg <= '0;
            tree_exp1   <= '0;
            tree_exp2   <= '0;
            out_valid   <= 1'b0;
            out_frac    <= '0;
            out_exp     <= '0;
            out_trunc   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            s1_vld_reg <= accept;
            if (s1_vld_reg) begin
                acc_reg     <= acc_next;
                acc_exp_reg <= acc_exp_next;
                first_reg   <= 1'b0;
            end
            if (accept) begin
                tree_exp1 <= in_exp1;
                tree_exp2 <= in_exp2;
                count_reg <= count_reg + 1'b1;
                if (state_reg == IDLE) first_reg <= 1'b1;
                if (count_hit && !in_last) trunc_reg <= 1'b1;
            end
            // First OUT cycle loads the result; later OUT cycles wait for the sink.
            if (state_reg == OUT) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_frac  <= acc_reg;
                    out_exp   <= acc_exp_reg;
                    out_trunc <= trunc_reg;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                    count_reg <= '0;
                    trunc_reg <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bfp_dot_sequencer.sv
// Bench for bfp_dot_sequencer: a scripted tree reads its result from the low lane
// bits of each presented chunk; directed cases then random dot products vs a model.
module tb_bfp_dot_sequencer;

    localparam int SF_W   = 11;
    localparam int EXP_W  = 5;
    localparam int MAXC   = 4;
    localparam int TREE_W = 2*SF_W + 2;
    localparam int ACC_W  = TREE_W + $clog2(MAXC);
    localparam int LW     = 8*SF_W;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid, in_ready, in_last;
    logic [EXP_W-1:0]         in_exp1, in_exp2;
    logic [LW-1:0]            in_lanes;
    logic [LW-1:0]            tree_lanes;
    logic [EXP_W-1:0]         tree_exp1, tree_exp2;
    logic signed [TREE_W-1:0] tree_result;
    logic [EXP_W:0]           tree_result_exp;
    logic                     out_valid, out_ready, out_trunc, busy;
    logic signed [ACC_W-1:0]  out_frac;
    logic [EXP_W:0]           out_exp;

    int errors = 0;
    int checks = 0;

    logic [LW-1:0]    lanes_q;
    logic [EXP_W-1:0] e1_q, e2_q;
    longint           rv[MAXC];
    int               re[MAXC];

    always #5 clk = ~clk;

    assign tree_result     = tree_lanes[TREE_W-1:0];
    assign tree_result_exp = tree_lanes[TREE_W +: EXP_W+1];

    bfp_dot_sequencer #(
        .SF_W(SF_W), .EXP_W(EXP_W), .MAX_CHUNKS(MAXC), .TREE_W(TREE_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_exp1(in_exp1), .in_exp2(in_exp2), .in_lanes(in_lanes),
        .tree_lanes(tree_lanes), .tree_exp1(tree_exp1), .tree_exp2(tree_exp2),
        .tree_result(tree_result), .tree_result_exp(tree_result_exp),
        .out_valid(out_valid), .out_ready(out_ready), .out_frac(out_frac),
        .out_exp(out_exp), .out_trunc(out_trunc), .busy(busy)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Floor of v / 2^d, with full sign fill once d reaches the accumulator width.
    function automatic longint floor_shift(input longint v, input int d);
        longint p, q;
        if (d >= ACC_W) return (v < 0) ? -64'sd1 : 64'sd0;
        p = 64'sd1 <<< d;
        q = v / p;
        if (v < 0 && q * p != v) q = q - 1;
        return q;
    endfunction

    function automatic void ref_product(input int n, output longint f, output int x);
        f = rv[0];
        x = re[0];
        for (int i = 1; i < n; i++) begin
            if (re[i] >= x) begin
                f = floor_shift(f, re[i] - x) + rv[i];
                x = re[i];
            end else begin
                f = f + floor_shift(rv[i], x - re[i]);
            end
        end
    endfunction

    task automatic drive_chunk(input longint val, input int ex, input bit last);
        logic [95:0] r;
        logic [5:0]  ex6;
        r   = {$urandom, $urandom, $urandom};
        ex6 = ex[5:0];
        lanes_q = r[LW-1:0];
        lanes_q[TREE_W-1:0] = val[TREE_W-1:0];
        lanes_q[TREE_W +: EXP_W+1] = ex6;
        e1_q = EXP_W'($urandom);
        e2_q = EXP_W'($urandom);
        in_lanes = lanes_q;
        in_exp1  = e1_q;
        in_exp2  = e2_q;
        in_last  = last;
        in_valid = 1'b1;
    endtask

    task automatic accept_checked(input string tag);
        int n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({tag, "_lanes_lo"}, tree_lanes[63:0], lanes_q[63:0]);
        check({tag, "_lanes_hi"}, tree_lanes[LW-1:64], lanes_q[LW-1:64]);
        check({tag, "_exp1"}, tree_exp1, e1_q);
        check({tag, "_exp2"}, tree_exp2, e2_q);
    endtask

    task automatic send(input string tag, input longint val, input int ex, input bit last);
        drive_chunk(val, ex, last);
        accept_checked(tag);
    endtask

    task automatic recv(input string tag, input longint ef, input int ee, input bit et, input int hold);
        int n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_frac"}, out_frac, ef);
        check({tag, "_exp"}, out_exp, ee);
        check({tag, "_trunc"}, out_trunc, et);
        $display("product %s frac=%0d exp=%0d trunc=%0d hold=%0d", tag, out_frac, out_exp, out_trunc, hold);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_frac"}, out_frac, ef);
            check({tag, "_hold_exp"}, out_exp, ee);
            check({tag, "_hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_done_valid"}, out_valid, 0);
        check({tag, "_done_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint ef;
        int     ee, nch, gap;

        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_exp1 = '0; in_exp2 = '0; in_lanes = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_frac", out_frac, 0);
        check("rst_tree_lanes", tree_lanes[63:0], 0);

        // Single chunk; out_ready raised early must not cut the result short.
        out_ready = 1'b1;
        send("single", 1000, 10, 1'b1);
        check("lat_t0_valid", out_valid, 0);
        check("lat_t0_busy", busy, 1);
        @(posedge clk); #1;
        check("lat_t1_valid", out_valid, 0);
        @(posedge clk); #1;
        check("lat_t2_valid", out_valid, 1);
        check("single_frac", out_frac, 1000);
        check("single_exp", out_exp, 10);
        check("single_trunc", out_trunc, 0);
        $display("product single frac=%0d exp=%0d trunc=%0d", out_frac, out_exp, out_trunc);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("single_done_valid", out_valid, 0);
        check("single_done_in_ready", in_ready, 1);

        send("fwd_c0", 1000, 10, 1'b0);
        send("fwd_c1", 800, 12, 1'b1);
        recv("fwd", 1050, 12, 1'b0, 0);

        send("rev_c0", 800, 12, 1'b0);
        send("rev_c1", 1000, 10, 1'b1);
        recv("rev", 1050, 12, 1'b0, 1);

        send("neg_c0", -7, 3, 1'b0);
        send("neg_c1", 0, 5, 1'b1);
        recv("neg", -2, 5, 1'b0, 0);

        send("wide_c0", 5, 0, 1'b0);
        send("wide_c1", 1, 31, 1'b1);
        recv("wide", 1, 31, 1'b0, 0);

        // Six chunks without in_last: forced end after four, the rest form a new product.
        for (int c = 0; c < MAXC; c++) send("trunc_c", 100, 4, 1'b0);
        check("trunc_in_ready_low", in_ready, 0);
        drive_chunk(100, 4, 1'b0);
        recv("trunc", 400, 4, 1'b1, 2);
        accept_checked("trunc_c5");
        send("trunc_c6", 100, 4, 1'b1);
        recv("after_trunc", 200, 4, 1'b0, 0);

        // Backpressure with the next chunk held at the input.
        send("bp_c0", 300, 7, 1'b0);
        send("bp_c1", -40, 9, 1'b1);
        drive_chunk(60, 1, 1'b1);
        recv("bp", 35, 9, 1'b0, 5);
        accept_checked("bp_next");
        recv("bp_next", 60, 1, 1'b0, 0);

        // Reset in the middle of a product discards the partial sum.
        send("rst_c0", 123, 5, 1'b0);
        send("rst_c1", 456, 6, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        send("post_rst", 50, 2, 1'b1);
        recv("post_rst", 50, 2, 1'b0, 0);

        for (int p = 0; p < 30; p++) begin
            nch = $urandom_range(1, MAXC);
            for (int c = 0; c < nch; c++) begin
                rv[c] = longint'($urandom_range(0, 2097152)) - 64'sd1048576;
                re[c] = $urandom_range(0, 63);
                gap   = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                end
                send("rnd_c", rv[c], re[c], (c == nch-1) && (nch < MAXC));
            end
            ref_product(nch, ef, ee);
            recv("rnd", ef, ee, nch == MAXC, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
